// File: rtl/cmos_line_pack_pkg.sv
// Shared types and constants for the DVP line packer.
package cmos_line_pack_pkg;

  localparam int unsigned DEF_IMG_H     = 1280;
  localparam int unsigned DEF_IMG_V     = 720;
  localparam int unsigned BYTES_PER_PIX = 2;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned BYTE_CNT_W    = 12;
  localparam int unsigned LINE_CNT_W    = 11;
  localparam int unsigned GEOM_W        = 16;

  // One-hot capture states, same encoding style as the sender FSM.
  typedef enum logic [2:0] {
    WAIT_VS = 3'b001,
    ARM     = 3'b010,
    CAPTURE = 3'b100
  } cap_state_e;

endpackage

// File: rtl/cmos_line_pack_if.sv
// Line-FIFO write bus plus line markers from the packer to the UDP line sender.
//   fifo_wr/fifo_wr_data : byte write strobe and data
//   fifo_clr             : one-cycle FIFO clear at frame start
//   href_end             : one-cycle pulse after the last byte of a line
//   if_first_href/if_last_href : line 0 / line IMG_V-1 flags
interface cmos_line_pack_if;
  import cmos_line_pack_pkg::*;

  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              fifo_clr;
  logic              href_end;
  logic              if_first_href;
  logic              if_last_href;

  modport master (
    output fifo_wr, fifo_wr_data, fifo_clr, href_end, if_first_href, if_last_href
  );

  modport slave (
    input fifo_wr, fifo_wr_data, fifo_clr, href_end, if_first_href, if_last_href
  );
endinterface

// File: rtl/cmos_edge_sync.sv
// DVP input registers and edge pulses.
//   vsync/href/data : raw sensor pins
//   data_d/href_d   : pins registered once
//   vs_active_c     : registered vsync is at its active level
//   vs_start_c      : first cycle of active vsync
//   href_rise_c/href_fall_c : registered href edges
module cmos_edge_sync
  import cmos_line_pack_pkg::*;
#(
  parameter bit VS_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_d,
  output logic              href_d,
  output logic              vs_active_c,
  output logic              vs_start_c,
  output logic              href_rise_c,
  output logic              href_fall_c
);

  logic vs_d;
  logic vs_dd;
  logic href_dd;

  // Vsync history resets to inactive so a held-inactive pin never fakes a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d    <= ~VS_POL;
      vs_dd   <= ~VS_POL;
      href_d  <= 1'b0;
      href_dd <= 1'b0;
      data_d  <= '0;
    end else begin
      vs_d    <= vsync;
      vs_dd   <= vs_d;
      href_d  <= href;
      href_dd <= href_d;
      data_d  <= data;
    end
  end

  assign vs_active_c = (vs_d == VS_POL);
  assign vs_start_c  = vs_active_c && (vs_dd != VS_POL);
  assign href_rise_c = href_d && !href_dd;
  assign href_fall_c = href_dd && !href_d;

endmodule

// File: rtl/cmos_line_pack.sv
// Packs OV5640 DVP lines into the UDP sender's line FIFO.
//   clk/rst_n         : pixel clock, async active-low reset
//   cmos_vsync/href/data : sensor DVP bus
//   frame_en          : capture enable, sampled at frame start
//   fifo_if           : FIFO write bus and line markers (master side)
//   cmos_h/cmos_v     : header geometry constants
//   line_len_err      : sticky, a forwarded line had the wrong byte count
module cmos_line_pack
  import cmos_line_pack_pkg::*;
#(
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned IMG_V  = DEF_IMG_V,
  parameter bit          VS_POL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmos_vsync,
  input  logic                cmos_href,
  input  logic [DATA_W-1:0]   cmos_data,
  input  logic                frame_en,
  cmos_line_pack_if.master    fifo_if,
  output logic [GEOM_W-1:0]   cmos_h,
  output logic [GEOM_W-1:0]   cmos_v,
  output logic                line_len_err
);

  localparam logic [BYTE_CNT_W-1:0] LINE_BYTES = BYTE_CNT_W'(BYTES_PER_PIX * IMG_H);
  localparam logic [LINE_CNT_W-1:0] LAST_LINE  = LINE_CNT_W'(IMG_V - 1);

  logic [DATA_W-1:0]     data_d;
  logic                  href_d;
  logic                  vs_active_c;
  logic                  vs_start_c;
  logic                  href_rise_c;
  logic                  href_fall_c;

  cap_state_e            state_q, state_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d, cnt_cur;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic                  en_q;
  logic                  wr_d, end_d, err_d, first_d, last_d;

  cmos_edge_sync #(.VS_POL(VS_POL)) u_edge_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (cmos_vsync),
    .href        (cmos_href),
    .data        (cmos_data),
    .data_d      (data_d),
    .href_d      (href_d),
    .vs_active_c (vs_active_c),
    .vs_start_c  (vs_start_c),
    .href_rise_c (href_rise_c),
    .href_fall_c (href_fall_c)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_VS;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      if (vs_start_c) en_q <= frame_en;
    end
  end

  // Next state, counters and next output values.
  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    byte_cnt_d = byte_cnt_q;
    wr_d       = 1'b0;
    end_d      = 1'b0;
    err_d      = line_len_err;
    first_d    = 1'b0;
    last_d     = 1'b0;

    // The rising-edge byte is counted from zero, so it sees count 0 itself.
    cnt_cur = href_rise_c ? '0 : byte_cnt_q;
    if (href_d) byte_cnt_d = (cnt_cur == '1) ? cnt_cur : cnt_cur + 1'b1;

    case (state_q)
      WAIT_VS: ;
      ARM: begin
        if (!vs_active_c) state_d = en_q ? CAPTURE : WAIT_VS;
      end
      CAPTURE: begin
        wr_d    = href_d && (cnt_cur < LINE_BYTES);
        first_d = (line_cnt_q == '0);
        last_d  = (line_cnt_q == LAST_LINE);
        if (href_fall_c) begin
          end_d = 1'b1;
          if (byte_cnt_q != LINE_BYTES) err_d = 1'b1;
          if (line_cnt_q == LAST_LINE) begin
            line_cnt_d = '0;
            state_d    = WAIT_VS;
          end else begin
            line_cnt_d = line_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase

    // Frame start overrides everything; a line cut by vsync is not reported.
    if (vs_start_c) begin
      state_d    = ARM;
      line_cnt_d = '0;
      wr_d       = 1'b0;
      end_d      = 1'b0;
      err_d      = line_len_err;
      first_d    = 1'b0;
      last_d     = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_if.fifo_wr       <= 1'b0;
      fifo_if.fifo_wr_data  <= '0;
      fifo_if.fifo_clr      <= 1'b0;
      fifo_if.href_end      <= 1'b0;
      fifo_if.if_first_href <= 1'b0;
      fifo_if.if_last_href  <= 1'b0;
      line_len_err          <= 1'b0;
      cmos_h                <= GEOM_W'(IMG_H);
      cmos_v                <= GEOM_W'(IMG_V);
    end else begin
      fifo_if.fifo_wr       <= wr_d;
      if (wr_d) fifo_if.fifo_wr_data <= data_d;
      fifo_if.fifo_clr      <= vs_start_c;
      fifo_if.href_end      <= end_d;
      fifo_if.if_first_href <= first_d;
      fifo_if.if_last_href  <= last_d;
      line_len_err          <= err_d;
      cmos_h                <= GEOM_W'(IMG_H);
      cmos_v                <= GEOM_W'(IMG_V);
    end
  end

endmodule

// File: tb/tb_cmos_line_pack.sv
// Directed bench for cmos_line_pack with a 4-pixel, 3-line geometry.
module tb_cmos_line_pack;
  import cmos_line_pack_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmos_vsync;
  logic       cmos_href;
  logic [7:0] cmos_data;
  logic       frame_en;
  logic [15:0] cmos_h;
  logic [15:0] cmos_v;
  logic       line_len_err;

  cmos_line_pack_if fifo_if ();

  cmos_line_pack #(.IMG_H(4), .IMG_V(3), .VS_POL(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmos_vsync   (cmos_vsync),
    .cmos_href    (cmos_href),
    .cmos_data    (cmos_data),
    .frame_en     (frame_en),
    .fifo_if      (fifo_if),
    .cmos_h       (cmos_h),
    .cmos_v       (cmos_v),
    .line_len_err (line_len_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int         cyc = 0;
  logic [7:0] wr_q[$];
  int         n_wr, n_end, n_clr, overlap;
  int         first_wr_cyc, clr_cyc, vs_cyc, line_start_cyc;
  logic [7:0] first_bits, last_bits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    wr_q.delete();
    n_wr = 0; n_end = 0; n_clr = 0; overlap = 0;
    first_wr_cyc = -1; clr_cyc = -1;
    first_bits = '0; last_bits = '0;
  endtask

  // One clock with the given pins; outputs sampled 1 time unit after the edge.
  task automatic step(input logic vs, input logic hr, input logic [7:0] d);
    cmos_vsync = vs; cmos_href = hr; cmos_data = d;
    @(posedge clk); #1;
    cyc++;
    if (fifo_if.fifo_wr) begin
      wr_q.push_back(fifo_if.fifo_wr_data);
      n_wr++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    if (fifo_if.href_end) begin
      n_end++;
      first_bits = {first_bits[6:0], fifo_if.if_first_href};
      last_bits  = {last_bits[6:0], fifo_if.if_last_href};
    end
    if (fifo_if.fifo_clr) begin
      n_clr++;
      if (clr_cyc < 0) clr_cyc = cyc;
      if (fifo_if.fifo_wr) overlap++;
    end
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 8'h00);
    vs_cyc = cyc;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, base + 8'(i));
      if (i == 0) line_start_cyc = cyc;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_data(input string tag, input int start, input int n, input logic [7:0] base);
    logic [7:0] obs;
    for (int i = 0; i < n; i++) begin
      obs = (start + i < wr_q.size()) ? wr_q[start + i] : 8'hxx;
      check(tag, 32'(obs), 32'(base + 8'(i)));
    end
  endtask

  initial begin
    int l0_start;
    rst_n = 1'b0; cmos_vsync = 1'b0; cmos_href = 1'b0; cmos_data = 8'h00; frame_en = 1'b0;
    clear_obs();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Reset state.
    check("rst_fifo_wr",  32'(fifo_if.fifo_wr), 32'd0);
    check("rst_fifo_clr", 32'(fifo_if.fifo_clr), 32'd0);
    check("rst_href_end", 32'(fifo_if.href_end), 32'd0);
    check("rst_first",    32'(fifo_if.if_first_href), 32'd0);
    check("rst_last",     32'(fifo_if.if_last_href), 32'd0);
    check("rst_err",      32'(line_len_err), 32'd0);
    check("rst_cmos_h",   32'(cmos_h), 32'd4);
    check("rst_cmos_v",   32'(cmos_v), 32'd3);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);

    // 1: nominal frame, three 8-byte lines.
    frame_en = 1'b1;
    clear_obs();
    vsync_pulse();
    send_line(8, 8'h10);
    l0_start = line_start_cyc;
    send_line(8, 8'h20);
    send_line(8, 8'h30);
    check("t1_clr_cnt",  32'(n_clr), 32'd1);
    check("t1_clr_cyc",  32'(clr_cyc), 32'(vs_cyc + 1));
    check("t1_wr_lat",   32'(first_wr_cyc), 32'(l0_start + 1));
    check("t1_wr_cnt",   32'(n_wr), 32'd24);
    check_data("t1_data_l0", 0, 8, 8'h10);
    check_data("t1_data_l1", 8, 8, 8'h20);
    check_data("t1_data_l2", 16, 8, 8'h30);
    check("t1_end_cnt",  32'(n_end), 32'd3);
    check("t1_first",    32'(first_bits), 32'b100);
    check("t1_last",     32'(last_bits), 32'b001);
    check("t1_err",      32'(line_len_err), 32'd0);
    check("t1_overlap",  32'(overlap), 32'd0);
    // Line after the last forwarded line is ignored.
    send_line(8, 8'h38);
    check("t1_extra_wr",  32'(n_wr), 32'd24);
    check("t1_extra_end", 32'(n_end), 32'd3);
    check("t1_idle_first", 32'(fifo_if.if_first_href), 32'd0);
    check("t1_idle_last",  32'(fifo_if.if_last_href), 32'd0);

    // 2: frame_en low at vsync, raised mid-frame.
    frame_en = 1'b0;
    clear_obs();
    vsync_pulse();
    send_line(8, 8'h40);
    frame_en = 1'b1;
    send_line(8, 8'h48);
    send_line(8, 8'h50);
    check("t2_clr_cnt", 32'(n_clr), 32'd1);
    check("t2_wr_cnt",  32'(n_wr), 32'd0);
    check("t2_end_cnt", 32'(n_end), 32'd0);

    // 3: long line of 10 bytes, then two normal lines.
    clear_obs();
    vsync_pulse();
    send_line(10, 8'h60);
    check("t3_wr_cnt",  32'(n_wr), 32'd8);
    check("t3_end_cnt", 32'(n_end), 32'd1);
    check("t3_err",     32'(line_len_err), 32'd1);
    check_data("t3_data", 0, 8, 8'h60);
    send_line(8, 8'h70);
    send_line(8, 8'h80);
    check("t3_wr_tot",  32'(n_wr), 32'd24);
    check("t3_end_tot", 32'(n_end), 32'd3);

    // 6: reset in the middle of line 0.
    clear_obs();
    vsync_pulse();
    step(1'b0, 1'b1, 8'h90);
    step(1'b0, 1'b1, 8'h91);
    step(1'b0, 1'b1, 8'h92);
    check("t6_pre_wr",    32'(fifo_if.fifo_wr), 32'd1);
    check("t6_pre_first", 32'(fifo_if.if_first_href), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_wr",    32'(fifo_if.fifo_wr), 32'd0);
    check("t6_rst_data",  32'(fifo_if.fifo_wr_data), 32'd0);
    check("t6_rst_first", 32'(fifo_if.if_first_href), 32'd0);
    check("t6_rst_err",   32'(line_len_err), 32'd0);
    check("t6_rst_h",     32'(cmos_h), 32'd4);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    clear_obs();
    send_line(8, 8'h98);
    send_line(8, 8'h9c);
    check("t6_post_wr",  32'(n_wr), 32'd0);
    check("t6_post_end", 32'(n_end), 32'd0);

    // 4: short line of 6 bytes, then normal lines; capture resumes after vsync.
    clear_obs();
    vsync_pulse();
    check("t4_err_pre", 32'(line_len_err), 32'd0);
    send_line(6, 8'hA0);
    check("t4_wr_short", 32'(n_wr), 32'd6);
    check("t4_end_short", 32'(n_end), 32'd1);
    check("t4_err",       32'(line_len_err), 32'd1);
    send_line(8, 8'hB0);
    send_line(8, 8'hC0);
    check("t4_wr_cnt",  32'(n_wr), 32'd22);
    check_data("t4_data_l0", 0, 6, 8'hA0);
    check_data("t4_data_l1", 6, 8, 8'hB0);
    check("t4_end_cnt", 32'(n_end), 32'd3);
    check("t4_first",   32'(first_bits), 32'b100);
    check("t4_last",    32'(last_bits), 32'b001);
    check("t4_err_hold", 32'(line_len_err), 32'd1);

    // 5: vsync rises during line 1 while href is still high.
    clear_obs();
    vsync_pulse();
    send_line(8, 8'hD0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hE0 + 8'(i));
    step(1'b1, 1'b1, 8'hE4);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    check("t5_clr_cnt", 32'(n_clr), 32'd2);
    check("t5_wr_cnt",  32'(n_wr), 32'd12);
    check_data("t5_partial", 8, 4, 8'hE0);
    check("t5_end_cnt", 32'(n_end), 32'd1);
    check("t5_overlap", 32'(overlap), 32'd0);
    clear_obs();
    send_line(8, 8'h11);
    send_line(8, 8'h21);
    send_line(8, 8'h31);
    check("t5_nf_wr",    32'(n_wr), 32'd24);
    check_data("t5_nf_data", 0, 8, 8'h11);
    check("t5_nf_end",   32'(n_end), 32'd3);
    check("t5_nf_first", 32'(first_bits), 32'b100);
    check("t5_nf_last",  32'(last_bits), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmos_line_pack.md
Name: cmos_line_pack

Overview:
- Capture-side stage that feeds the Ethernet UDP line sender.
- Samples the OV5640 DVP bus (vsync/href/8-bit data, 2 bytes per RGB565 pixel) and writes each line's bytes into the sender's line FIFO.
- Pulses href_end at the end of each line and supplies first-line/last-line flags plus the line geometry that goes into the frame header.
- Runs entirely in the camera pixel-clock domain.

Parameters:
- IMG_H, 1280, pixels per line; bytes per line = 2*IMG_H.
- IMG_V, 720, lines per frame that are forwarded.
- VS_POL, 1, active level of cmos_vsync (1 = high during frame blanking pulse).

Ports:
- clk  in  1  camera pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmos_vsync  in  1  frame sync from sensor.
- cmos_href  in  1  line-valid from sensor.
- cmos_data  in  8  pixel byte, valid when cmos_href=1.
- frame_en  in  1  capture enable; sampled only at frame start.
- fifo_wr  out  1  FIFO write strobe.
- fifo_wr_data  out  8  FIFO write byte.
- fifo_clr  out  1  one-cycle FIFO clear at frame start.
- href_end  out  1  one-cycle pulse after the last byte of a forwarded line.
- if_first_href  out  1  current/just-finished line is line 0.
- if_last_href  out  1  current/just-finished line is line IMG_V-1.
- cmos_h  out  16  constant IMG_H (header field).
- cmos_v  out  16  constant IMG_V (header field).
- line_len_err  out  1  sticky: a forwarded line did not have exactly 2*IMG_H bytes.

Behaviour:
- Reset values: every output 0 except cmos_h=IMG_H and cmos_v=IMG_V. Internal state is WAIT_VS, and all counters are 0.
- Input stage: cmos_vsync, cmos_href and cmos_data are registered once (vs_d, href_d, data_d). A second href register (href_dd) is used for edge detection.
- Frame start (vs_start) is the cycle in which vs_d first equals VS_POL.
- State machine:
  - WAIT_VS: on vs_start, go to ARM.
  - ARM: waits out vsync. When vs_d returns to inactive: if frame_en was 1 at vs_start, go to CAPTURE; otherwise go to WAIT_VS.
  - CAPTURE: forwards lines. After href_end of line IMG_V-1, go to WAIT_VS.
  - Any vs_start seen in ARM or CAPTURE restarts the frame (go to ARM, line counter cleared). The partial frame is abandoned, and href_end is not issued for a line cut off by vsync.
- fifo_clr:
  - One-cycle pulse in the vs_start cycle, from every state, regardless of frame_en.
  - It takes priority: no fifo_wr is issued in the same cycle.
- Writing:
  - In CAPTURE, fifo_wr = href_d AND (byte_cnt < 2*IMG_H), and fifo_wr_data = data_d. Latency is 2 clk from pin to FIFO write.
  - byte_cnt (12 bit) increments on every href_d=1 cycle, saturates at 4095, and clears on the href_d rising edge.
  - Excess bytes are dropped.
- href_end:
  - Asserted in the cycle where href_dd=1 and href_d=0, in CAPTURE only.
  - On that same cycle, line_cnt increments.
  - If byte_cnt != 2*IMG_H at that point, set line_len_err. It is cleared only by reset.
  - The line is still reported, because the sender reads a fixed count.
- Flags:
  - if_first_href = (line_cnt==0).
  - if_last_href = (line_cnt==IMG_V-1).
  - Both are registered from line_cnt, so they are stable from line start through the href_end cycle and change the cycle after href_end.
  - Both are 0 outside CAPTURE.
- href lines arriving outside CAPTURE (in WAIT_VS or ARM, or after line IMG_V-1 has been forwarded) are ignored: no fifo_wr, no href_end.
- A one-cycle href glitch produces 1 byte written, href_end, and line_len_err set.
- line_cnt is 11 bit; it never exceeds IMG_V-1 because the machine leaves CAPTURE at the last line.
- Reset asserted mid-line returns to WAIT_VS immediately. Capture resumes only after the next full vs_start.

Decomposition:
- Shared package holds:
  - the state encodings WAIT_VS/ARM/CAPTURE (one-hot, 3 bit, same style as the sender FSM);
  - the default geometry constants 1280/720;
  - BYTES_PER_PIX=2.
- A natural sub-module is cmos_edge_sync: it holds the input registers and produces vs_start, href_rise and href_fall pulses.
- The FSM, counters and flags stay in cmos_line_pack.

Test Plan:
1. Nominal frame, IMG_H=4, IMG_V=3, frame_en=1:
   - Expect fifo_clr once at vsync.
   - Each line gives 8 fifo_wr with data matching the input 2 cycles later.
   - Expect three href_end pulses, with if_first_href=1 only at the first and if_last_href=1 only at the third.
   - line_len_err stays 0.
2. frame_en=0 at vsync:
   - fifo_clr pulses, but there is no fifo_wr and no href_end for the whole frame.
   - Raising frame_en mid-frame has no effect until the next vsync.
3. Long line of 10 bytes with IMG_H=4:
   - Only the first 8 bytes are written.
   - href_end is issued and line_len_err=1.
4. Short line of 6 bytes:
   - 6 writes, href_end is issued, line_len_err=1.
   - The next line with 8 bytes is written normally, and the flag stays 1.
5. vsync arrives during line 1 of 3:
   - fifo_clr pulses and no href_end is issued for the cut line.
   - The next frame starts with if_first_href=1 at line 0.
6. rst_n asserted mid-line:
   - All outputs are 0 asynchronously.
   - After release, hrefs are ignored until vsync, then normal capture resumes.
